seq_detect_param: RTL and testbench

Parametrised Moore serial-pattern detector, the generalised successor to the team's fixed 3-flip-flop state machines. It samples a serial bit stream `x` and asserts `F` while the last `N` accepted bits equal `PATTERN`. It exposes the match-progress state and keeps a saturating count of detections. The block sits on the serial input path and drives downstream framing and alarm logic.

---
 rtl/seq_detect_param.sv | 98 +++++++++
 tb/tb_seq_detect_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with KMP-style fallback and a
// saturating detection counter. Transition tables are fixed at elaboration.
module seq_detect_param #(
   parameter int unsigned    N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1101,
   parameter int unsigned    OVERLAP = 1,
   parameter int unsigned    CNT_W   = 8,
   localparam int unsigned   SW      = $clog2(N + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             x,
   input  logic             en,
   input  logic             clr_cnt,
   output logic             F,
   output logic [SW-1:0]    S,
   output logic [CNT_W-1:0] MATCH_CNT
);

   localparam int unsigned      NS      = 2 ** SW;
   localparam logic [SW-1:0]    S_IDLE  = '0;
   localparam logic [SW-1:0]    S_FULL  = SW'(N);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Longest suffix of (first k pattern bits, b) that is also a pattern prefix.
   function automatic int unsigned nxt_f(input int unsigned k, input logic b);
      logic [31:0]  pat;
      logic [31:0]  seq;
      logic [31:0]  mask;
      int unsigned  res;
      pat = 32'(PATTERN);
      if (k == N && OVERLAP == 0) begin
         return (b == PATTERN[N-1]) ? 32'd1 : 32'd0;
      end
      seq = ((pat >> (N - k)) << 1) | 32'(b);
      res = 0;
      for (int unsigned l = 1; l <= N; l++) begin
         if (l <= k + 1) begin
            mask = (32'd1 << l) - 32'd1;
            if ((seq & mask) == ((pat >> (N - l)) & mask)) res = l;
         end
      end
      return res;
   endfunction

   logic [SW-1:0]    nxt0 [NS];
   logic [SW-1:0]    nxt1 [NS];

   logic [SW-1:0]    s_q,   s_d;
   logic             f_q,   f_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit;

   // Encodings above N are unreachable; they map back to idle for safety.
   for (genvar k = 0; k < NS; k++) begin : g_tab
      if (k <= N) begin : g_live
         assign nxt0[k] = SW'(nxt_f(k, 1'b0));
         assign nxt1[k] = SW'(nxt_f(k, 1'b1));
      end else begin : g_dead
         assign nxt0[k] = S_IDLE;
         assign nxt1[k] = S_IDLE;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         s_q   <= S_IDLE;
         f_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         s_q   <= s_d;
         f_q   <= f_d;
         cnt_q <= cnt_d;
      end
   end

   // F is registered from the next state so it stays a pure state decode.
   always_comb begin
      s_d   = s_q;
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (en) begin
         s_d = x ? nxt1[s_q] : nxt0[s_q];
         hit = (s_d == S_FULL);
      end
      f_d = (s_d == S_FULL);
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (hit && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign S         = s_q;
   assign F         = f_q;
   assign MATCH_CNT = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three parameterisations driven by one stream,
// table-driven vectors through a scoreboard queue plus a mid-cycle reset case.
module tb_seq_detect_param;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic x = 1'b0;
   logic en = 1'b0;
   logic clr_cnt = 1'b0;

   logic       fa, fb, fc;
   logic [2:0] sa, sb;
   logic [1:0] sc;
   logic [7:0] ca, cb;
   logic [1:0] cc;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   // A: 1101 overlap, B: 1101 no overlap, C: 11 overlap with 2-bit counter
   seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_a (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
      .F(fa), .S(sa), .MATCH_CNT(ca));
   seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_b (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
      .F(fb), .S(sb), .MATCH_CNT(cb));
   seq_detect_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_c (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
      .F(fc), .S(sc), .MATCH_CNT(cc));

   typedef struct {
      int r;  int x;  int en; int clr;
      int sa; int fa; int ca;
      int sb; int fb; int cb;
      int sc; int fc; int cc;
   } vec_t;

   vec_t sb_q[$];

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic reset_pulse();
      RESET = 1'b0;
      #2;
      RESET = 1'b1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      if (v.r != 0) reset_pulse();
      sb_q.push_back(v);
      x       = 1'(v.x);
      en      = 1'(v.en);
      clr_cnt = 1'(v.clr);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      chk("A.S", idx, int'(sa), e.sa);
      chk("A.F", idx, int'(fa), e.fa);
      chk("A.CNT", idx, int'(ca), e.ca);
      chk("B.S", idx, int'(sb), e.sb);
      chk("B.F", idx, int'(fb), e.fb);
      chk("B.CNT", idx, int'(cb), e.cb);
      chk("C.S", idx, int'(sc), e.sc);
      chk("C.F", idx, int'(fc), e.fc);
      chk("C.CNT", idx, int'(cc), e.cc);
   endtask

   task automatic drive_bit(input logic b);
      x       = b;
      en      = 1'b1;
      clr_cnt = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   vec_t tbl [31] = '{
      // basic stream 1101101
      '{1,1,1,0, 1,0,0, 1,0,0, 1,0,0},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,1},
      '{0,0,1,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,1,1,0, 4,1,1, 4,1,1, 1,0,1},
      '{0,1,1,0, 2,0,1, 1,0,1, 2,1,2},
      '{0,0,1,0, 3,0,1, 0,0,1, 0,0,2},
      '{0,1,1,0, 4,1,2, 1,0,1, 1,0,2},
      // fallback 11101
      '{1,1,1,0, 1,0,0, 1,0,0, 1,0,0},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,1},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,2},
      '{0,0,1,0, 3,0,0, 3,0,0, 0,0,2},
      '{0,1,1,0, 4,1,1, 4,1,1, 1,0,2},
      // enable gating, counter clear while disabled
      '{1,1,1,0, 1,0,0, 1,0,0, 1,0,0},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,1},
      '{0,0,1,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,1,0,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,0,0,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,1,0,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,0,0,0, 3,0,0, 3,0,0, 0,0,1},
      '{0,1,0,1, 3,0,0, 3,0,0, 0,0,0},
      '{0,1,1,0, 4,1,1, 4,1,1, 1,0,0},
      // saturation, clear beating a coincident increment
      '{1,1,1,0, 1,0,0, 1,0,0, 1,0,0},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,1},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,2},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,3},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,3},
      '{0,1,1,0, 2,0,0, 2,0,0, 2,1,3},
      '{0,1,1,1, 2,0,0, 2,0,0, 2,1,0},
      '{0,0,1,0, 3,0,0, 3,0,0, 0,0,0},
      '{0,1,1,0, 4,1,1, 4,1,1, 1,0,0},
      '{0,1,1,1, 2,0,0, 1,0,0, 2,1,0}
   };

   logic [19:0] stream;
   vec_t        post_rst;

   initial begin
      #3;
      chk("rst.A.S", -1, int'(sa), 0);
      chk("rst.A.F", -1, int'(fa), 0);
      chk("rst.A.CNT", -1, int'(ca), 0);
      chk("rst.C.CNT", -1, int'(cc), 0);
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 31; i++) apply(tbl[i], i);

      // reach S=3 with five detections on A: 1101 + 4x 101 + 10
      reset_pulse();
      stream = 20'b1101_101_101_101_101_10;
      for (int i = 19; i >= 0; i--) drive_bit(stream[i]);
      chk("pre.A.S", 100, int'(sa), 3);
      chk("pre.A.CNT", 100, int'(ca), 5);

      // asynchronous reset between edges, observed before the next edge
      #2;
      RESET = 1'b0;
      #1;
      chk("async.A.S", 101, int'(sa), 0);
      chk("async.A.F", 101, int'(fa), 0);
      chk("async.A.CNT", 101, int'(ca), 0);
      chk("async.B.S", 101, int'(sb), 0);
      chk("async.C.S", 101, int'(sc), 0);
      chk("async.C.CNT", 101, int'(cc), 0);
      #2;
      RESET = 1'b1;
      post_rst = '{0,1,1,0, 1,0,0, 1,0,0, 1,0,0};
      apply(post_rst, 102);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
